// File: rtl/fp16_to_int.sv
// Converts an IEEE-754 binary16 operand to a saturating OUT_W-bit signed integer,
// truncating toward zero, using a one-bit-per-cycle shifter behind a valid/ready handshake.
module fp16_to_int #(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_int,
  output logic             ovf,
  output logic             inexact,
  output logic             nan
);

  typedef enum logic [1:0] {IDLE, SHIFT, SIGN, DONE} state_t;

  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [32:0]      LIM_NEG = 33'd1 << (OUT_W-1);
  localparam logic [32:0]      LIM_POS = LIM_NEG - 33'd1;

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_mag;
  logic [4:0]       r_cnt;
  logic             r_left;
  logic             r_sticky;
  logic             r_sign;
  logic [OUT_W-1:0] r_out_int;
  logic             r_ovf;
  logic             r_inexact;
  logic             r_nan;

  logic             w_accept;
  logic [4:0]       w_exp;
  logic [9:0]       w_frac;
  logic [4:0]       w_cnt_in;
  logic             w_special;
  logic [32:0]      w_mag_wide;
  logic [32:0]      w_mag_neg;
  logic             w_over;

  // Gating with rst_n keeps in_ready low while reset is held, yet high on the first cycle after release.
  assign in_ready  = (r_state == IDLE) && rst_n;
  assign out_valid = (r_state == DONE);
  assign out_int   = r_out_int;
  assign ovf       = r_ovf;
  assign inexact   = r_inexact;
  assign nan       = r_nan;

  assign w_accept   = in_valid && in_ready;
  assign w_exp      = in_data[14:10];
  assign w_frac     = in_data[9:0];
  assign w_cnt_in   = (w_exp > 5'd25) ? (w_exp - 5'd25) : (5'd25 - w_exp);
  assign w_special  = (w_exp == 5'd0) || (w_exp == 5'd31);

  assign w_mag_wide = {17'd0, r_mag};
  assign w_mag_neg  = 33'd0 - w_mag_wide;
  assign w_over     = w_mag_wide > (r_sign ? LIM_NEG : LIM_POS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_accept) begin
               if (w_special)              w_next = DONE;
               else if (w_cnt_in == 5'd0)  w_next = SIGN;
               else                        w_next = SHIFT;
             end
      SHIFT: if (r_cnt == 5'd1) w_next = SIGN;
      SIGN:  w_next = DONE;
      DONE:  if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag     <= '0;
      r_cnt     <= '0;
      r_left    <= 1'b0;
      r_sticky  <= 1'b0;
      r_sign    <= 1'b0;
      r_out_int <= '0;
      r_ovf     <= 1'b0;
      r_inexact <= 1'b0;
      r_nan     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_sign   <= in_data[15];
          r_sticky <= 1'b0;
          if (w_exp == 5'd0) begin
            r_out_int <= '0;
            r_ovf     <= 1'b0;
            r_inexact <= (w_frac != 10'd0);
            r_nan     <= 1'b0;
          end else if (w_exp == 5'd31) begin
            r_inexact <= 1'b0;
            if (w_frac != 10'd0) begin
              r_out_int <= '0;
              r_ovf     <= 1'b0;
              r_nan     <= 1'b1;
            end else begin
              r_out_int <= in_data[15] ? SAT_NEG : SAT_POS;
              r_ovf     <= 1'b1;
              r_nan     <= 1'b0;
            end
          end else begin
            r_mag  <= {5'd0, 1'b1, w_frac};
            r_cnt  <= w_cnt_in;
            r_left <= (w_exp > 5'd25);
          end
        end
        SHIFT: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_left) begin
            r_mag <= r_mag << 1;
          end else begin
            r_mag    <= r_mag >> 1;
            r_sticky <= r_sticky | r_mag[0];
          end
        end
        SIGN: begin
          if (w_over) begin
            r_out_int <= r_sign ? SAT_NEG : SAT_POS;
            r_ovf     <= 1'b1;
          end else begin
            r_out_int <= r_sign ? w_mag_neg[OUT_W-1:0] : w_mag_wide[OUT_W-1:0];
            r_ovf     <= 1'b0;
          end
          r_inexact <= r_sticky;
          r_nan     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_to_int.sv
// Self-checking bench for fp16_to_int: directed corner operands plus random binary16
// values compared against an arithmetic reference model of the conversion.
module tb_fp16_to_int;

  localparam int OUT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_int;
  logic             ovf;
  logic             inexact;
  logic             nan;

  int n_checks;
  int n_fail;

  fp16_to_int #(.OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_int  (out_int),
    .ovf      (ovf),
    .inexact  (inexact),
    .nan      (nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value = {1,frac} * 2^(exp-25); integer part by truncation, then clamp to the signed range.
  function automatic void ref_model(input logic [15:0] d,
                                    output logic [OUT_W-1:0] r_int,
                                    output logic r_ovf, output logic r_inx,
                                    output logic r_nan, output int lat);
    int     e;
    longint m;
    longint ip;
    longint v;
    longint hi;
    longint lo;
    e  = int'(d[14:10]);
    m  = longint'({1'b1, d[9:0]});
    hi = (longint'(1) <<< (OUT_W-1)) - 1;
    lo = -(longint'(1) <<< (OUT_W-1));
    r_ovf = 1'b0; r_inx = 1'b0; r_nan = 1'b0;
    v = 0;
    if (e == 0) begin
      r_inx = (d[9:0] != 10'd0);
      lat   = 1;
    end else if (e == 31) begin
      lat = 1;
      if (d[9:0] != 10'd0) r_nan = 1'b1;
      else begin
        r_ovf = 1'b1;
        v     = d[15] ? lo : hi;
      end
    end else begin
      lat = ((e > 25) ? (e - 25) : (25 - e)) + 2;
      if (e >= 25) ip = m <<< (e - 25);
      else begin
        ip    = m >>> (25 - e);
        r_inx = ((ip <<< (25 - e)) != m);
      end
      v = d[15] ? -ip : ip;
      if (v > hi) begin v = hi; r_ovf = 1'b1; end
      if (v < lo) begin v = lo; r_ovf = 1'b1; end
    end
    r_int = OUT_W'(v);
  endfunction

  // Runs one operand through the DUT with in_valid held high (junk data) while busy,
  // checks latency/result, holds the result for hold_cyc cycles, then drains it.
  task automatic run_conv(input logic [15:0] d, input int hold_cyc, input string tag);
    logic [OUT_W-1:0] e_int;
    logic e_ovf, e_inx, e_nan;
    int   e_lat;
    int   lat;
    ref_model(d, e_int, e_ovf, e_inx, e_nan, e_lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before_accept: got %b want 1", tag, in_ready);
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_data = 16'($urandom);
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_data = 16'($urandom);
    end
    in_valid = 1'b0;
    n_checks++;
    if (lat !== e_lat || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency in=%h: got %0d (valid=%b) want %0d", tag, d, lat, out_valid, e_lat);
    end
    n_checks++;
    if ({out_int, ovf, inexact, nan} !== {e_int, e_ovf, e_inx, e_nan}) begin
      n_fail++;
      $display("FAIL %s result in=%h: got int=%h ovf=%b inx=%b nan=%b want int=%h ovf=%b inx=%b nan=%b",
               tag, d, out_int, ovf, inexact, nan, e_int, e_ovf, e_inx, e_nan);
    end
    for (int i = 0; i < hold_cyc; i++) begin
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, out_int, ovf, inexact, nan} !== {2'b10, e_int, e_ovf, e_inx, e_nan}) begin
        n_fail++;
        $display("FAIL %s hold cycle %0d: got valid=%b ready=%b int=%h flags=%b%b%b want valid=1 ready=0 int=%h",
                 tag, i, out_valid, in_ready, out_int, ovf, inexact, nan, e_int);
      end
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s drain: got valid=%b ready=%b want valid=0 ready=1", tag, out_valid, in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #3;
    n_checks++;
    if ({in_ready, out_valid, out_int, ovf, inexact, nan} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b valid=%b int=%h flags=%b%b%b want all 0",
               in_ready, out_valid, out_int, ovf, inexact, nan);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    run_conv(16'h3E00, 0, "one_point_five");
    run_conv(16'hCC80, 0, "minus_18");
    run_conv(16'h7BFF, 0, "max_finite_sat");
    run_conv(16'hF800, 0, "minus_32768");
    run_conv(16'hFC00, 0, "neg_inf");
    run_conv(16'h7C00, 0, "pos_inf");
    run_conv(16'h7E00, 0, "nan");
    run_conv(16'h0001, 0, "subnormal");
    run_conv(16'h8000, 0, "neg_zero");
    run_conv(16'h0400, 0, "min_normal");
    run_conv(16'h6400, 0, "exp25_no_shift");
    run_conv(16'hBC00, 0, "minus_one");
  endtask

  task automatic test_hold();
    run_conv(16'hCC80, 5, "hold_minus_18");
    run_conv(16'h7E00, 3, "hold_nan");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h3E00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_busy: got ready=%b valid=%b want 0 0", in_ready, out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_int, ovf, inexact, nan} !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: got ready=%b valid=%b int=%h flags=%b%b%b want all 0",
               in_ready, out_valid, out_int, ovf, inexact, nan);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
    end
    run_conv(16'h4500, 0, "after_reset_5");
  endtask

  task automatic test_random();
    logic [15:0] d;
    for (int i = 0; i < 150; i++) begin
      d = 16'($urandom);
      // Bias half the draws toward exponents that shift or saturate near the output width.
      if (i % 2 == 0) d[14:10] = 5'(20 + $urandom_range(0, 10));
      run_conv(d, int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp16_to_int.md
FP16_TO_INT -- requirements
Module: fp16_to_int

Interface
REQ-001 Parameter OUT_W, default 16, is the signed integer output width; legal range 12..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  producer has a half-precision result on in_data (driven from the FPU Rsem output).
REQ-005 in_ready  output  1  block can accept an operand this cycle.
REQ-006 in_data  input  16  IEEE-754 binary16 operand: sign[15], exponent[14:10] (bias 15), fraction[9:0].
REQ-007 out_valid  output  1  out_int and flags hold a completed conversion.
REQ-008 out_ready  input  1  consumer takes the result this cycle.
REQ-009 out_int  output  OUT_W  two's-complement integer result, truncated toward zero.
REQ-010 ovf  output  1  result was saturated.
REQ-011 inexact  output  1  non-zero fraction bits were discarded.
REQ-012 nan  output  1  operand was NaN.

Function
REQ-013 An input transfer occurs on a clock edge where in_valid=1 and in_ready=1; an output transfer occurs on an edge where out_valid=1 and out_ready=1.
REQ-014 The FSM states SHALL be IDLE, SHIFT, SIGN and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-015 On accept with exponent=0 (zero or subnormal): out_int=0; inexact=(fraction!=0); go to DONE.
REQ-016 On accept with exponent=31 and fraction!=0: out_int=0; nan=1; go to DONE.
REQ-017 On accept with exponent=31 and fraction=0: out_int=+2^(OUT_W-1)-1 (or -2^(OUT_W-1) if sign=1); ovf=1; go to DONE.
REQ-018 On accept of a normal operand: load 16-bit magnitude register with {1,fraction}; set cnt=|exponent-25| and direction (left if exponent>25, else right); clear sticky; go to SHIFT, or to SIGN if cnt=0.
REQ-019 In SHIFT, on each edge: shift magnitude one bit in the stored direction; decrement cnt; on a right shift, OR the bit shifted out into sticky; go to SIGN on the edge where cnt reaches 0.
REQ-020 In SIGN: magnitude limit is 2^(OUT_W-1)-1 for sign=0 and 2^(OUT_W-1) for sign=1.
REQ-021 In SIGN, if the magnitude exceeds the limit, load the saturated value with ovf=1; otherwise load out_int=sign ? -magnitude : magnitude.
REQ-022 In SIGN, set inexact=sticky and go to DONE.
REQ-023 Latency from the accept edge to out_valid high: 1 edge for REQ-015..017; cnt+2 edges for normal operands (maximum 26, for exponent=1).
REQ-024 In DONE, out_int and flags SHALL hold stable while out_ready=0; on the output-transfer edge go to IDLE. No new input is accepted on that same edge.
REQ-025 Flags and out_int are registered and change only on the edge entering DONE or on reset; -0 yields 0 with all flags 0.
REQ-026 in_valid while busy SHALL be ignored; in_data is sampled only at the accept edge.

Reset
REQ-027 rst_n low SHALL immediately force: state=IDLE, out_int=0, ovf=0, inexact=0, nan=0, out_valid=0, and in_ready=0.
REQ-028 Reset asserted mid-conversion SHALL abandon the operand with no output transfer; in_ready=1 on the first cycle after rst_n rises.

Verification
REQ-029 in_data=0x3E00 (1.5) -> out_int=1, inexact=1, ovf=0, nan=0; out_valid rises 12 edges after accept.
REQ-030 in_data=0xCC80 (-18) -> out_int=0xFFEE, all flags 0; 8-edge latency.
REQ-031 OUT_W=16 -> in_data=0x7BFF (65504) gives 0x7FFF with ovf=1; in_data=0xF800 (-32768) gives 0x8000 with ovf=0.
REQ-032 in_data=0xFC00 -> 0x8000 with ovf=1 and 1-edge latency; in_data=0x7E00 -> 0 with nan=1; in_data=0x0001 -> 0 with inexact=1.
REQ-033 Hold out_ready=0 for 5 cycles after out_valid -> out_int, flags and out_valid stay constant and in_ready stays 0; raise out_ready -> IDLE on the next edge.
REQ-034 Pull rst_n low during SHIFT of 0x3E00 -> outputs go to 0 immediately; after release, in_data=0x4500 -> out_int=5 with all flags 0.
